// File: rtl/alu_cmd_sequencer_if.sv
// Handshake and ALU-side signal bundle for alu_cmd_sequencer.
// slave is the sequencer's view; master is the surrounding environment's view.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;
    logic       rsp_illegal;

    logic [2:0] fifo_level;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op,
               rsp_valid, rsp_data, rsp_op, rsp_illegal, fifo_level
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op,
               rsp_valid, rsp_data, rsp_op, rsp_illegal, fifo_level
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: queues ALU commands in a small FIFO, issues them one at a
// time to an external registered ALU, and returns each result as a response.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus
);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  FULL = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    state_t        state_q;
    logic [18:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [2:0]    level_q;
    logic [2:0]    level_d;

    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic [2:0]    alu_op_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic [2:0]    rsp_op_q;
    logic          rsp_illegal_q;

    logic          cmd_ready;
    logic          push;
    logic          pop;
    logic [18:0]   head;

    assign cmd_ready = (level_q != FULL);
    assign head      = mem_q[rd_ptr_q];

    // Handshake decode: push on accepted command, pop when the FSM can issue.
    always_comb begin
        push = bus.cmd_valid && cmd_ready;
        pop  = 1'b0;
        if (level_q != '0) begin
            pop = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
        end
        level_d = level_q + {2'b00, push} - {2'b00, pop};
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
        end
    end

    // Sequencer FSM with FIFO pointers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_op_q      <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                alu_a_q  <= head[18:11];
                alu_b_q  <= head[10:3];
                alu_op_q <= head[2:0];
            end
            case (state_q)
                IDLE: begin
                    if (pop) state_q <= ISSUE;
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data_q    <= bus.alu_result;
                    rsp_op_q      <= alu_op_q;
                    rsp_illegal_q <= (alu_op_q[1:0] == 2'b11);
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= pop ? ISSUE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_op      = rsp_op_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign bus.fifo_level  = level_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a registered ALU model and a
// response scoreboard filled at command acceptance.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] op;
        logic       ill;
    } rsp_t;

    rsp_t        sb [$];
    int unsigned rsp_cyc [$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned n_rsp    = 0;
    rsp_t        mon_exp;
    rsp_t        mon_got;

    int unsigned acc;
    int unsigned idx;
    logic        took;
    logic [7:0]  held;
    logic [2:0]  op_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b100:  return a | b;
            3'b101:  return {a[6:0], 1'b0};
            3'b110:  return {1'b0, a[7:1]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // External ALU: result registered one clock after operands are presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.alu_result <= 8'h00;
        else        bus.alu_result <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    always @(posedge clk) cyc++;

    // Monitor: record accepted commands, compare completed responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                mon_exp.data = alu_fn(bus.cmd_a, bus.cmd_b, bus.cmd_op);
                mon_exp.op   = bus.cmd_op;
                mon_exp.ill  = (bus.cmd_op == 3'b011) || (bus.cmd_op == 3'b111);
                sb.push_back(mon_exp);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                rsp_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_got = sb.pop_front();
                    check("rsp_data", 32'(bus.rsp_data), 32'(mon_got.data));
                    check("rsp_op", 32'(bus.rsp_op), 32'(mon_got.op));
                    check("rsp_illegal", 32'(bus.rsp_illegal), 32'(mon_got.ill));
                end
            end
        end
    end

    // Called 1ns after a posedge; returns 1ns after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int unsigned g = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        @(negedge clk);
        while (!bus.cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("send_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned g = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain_in_time", 32'(g < 100), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_op    = 3'b000;
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
        check("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        check("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: rsp_valid appears only after the third edge past acceptance
        send(8'h0F, 8'h01, 3'b000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("latency_rsp_valid", 32'(bus.rsp_valid), 32'(i == 3));
        end
        drain();

        // Subtract wrap, shifts in order, logic ops, illegal opcodes
        send(8'h05, 8'h07, 3'b001);
        drain();
        send(8'h81, 8'h00, 3'b101);
        send(8'h81, 8'h00, 3'b110);
        drain();
        send(8'hF0, 8'h3C, 3'b010);
        send(8'hF0, 8'h0C, 3'b100);
        send(8'h12, 8'h34, 3'b011);
        send(8'hAB, 8'hCD, 3'b111);
        drain();

        // Backpressure: continuous offers with the response stalled
        bus.rsp_ready = 1'b0;
        acc = 0;
        idx = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'h11;
        bus.cmd_b     = 8'h21;
        bus.cmd_op    = op_tab[0];
        repeat (12) begin
            @(negedge clk);
            took = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                idx++;
                bus.cmd_a  = 8'((idx + 1) * 17);
                bus.cmd_b  = 8'(8'h21 + idx);
                bus.cmd_op = op_tab[idx % 5];
            end
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        held = bus.rsp_data;
        check("stall_accepted", acc, 32'd5);
        check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("stall_fifo_level", 32'(bus.fifo_level), 32'd4);
        @(negedge clk);
        check("stall_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
        check("stall_rsp_data_held", 32'(bus.rsp_data), 32'(held));
        n_rsp = 0;
        rsp_cyc.delete();
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        drain();
        check("stall_rsp_count", n_rsp, 32'd5);
        for (int i = 1; i < 5; i++) begin
            check("rsp_spacing",
                  (i < rsp_cyc.size()) ? rsp_cyc[i] - rsp_cyc[i-1] : 32'd0, 32'd3);
        end

        // Reset while in CAPTURE with two commands queued
        send(8'h01, 8'h02, 3'b000);
        send(8'h03, 8'h04, 3'b000);
        send(8'h05, 8'h06, 3'b000);
        check("pre_rst_fifo_level", 32'(bus.fifo_level), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_fifo_level", 32'(bus.fifo_level), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_rsp = 0;
        @(negedge clk);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (20) @(negedge clk);
        check("midrst_no_rsp", n_rsp, 32'd0);
        check("midrst_fifo_empty", 32'(bus.fifo_level), 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
